// File: rtl/memory_responder.sv
// memory_responder: data-memory command target. Byte-masked writes into a
// word array; reads return after READ_LATENCY cycles with a one-cycle valid pulse.
module memory_responder #(
  parameter int    MEM_WORDS     = 4096,
  parameter int    READ_LATENCY  = 2,
  parameter int    WRITE_LATENCY = 0,
  parameter string MEM_INIT_FILE = ""
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        mem_cmd_start,
  input  logic        mem_cmd_write,
  output logic        mem_cmd_ready,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  input  logic [31:0] mem_wmask,
  output logic [31:0] mem_rdata,
  output logic        mem_rdata_valid
);

  localparam int         AW      = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
  localparam logic [3:0] RD_LOAD = 4'(READ_LATENCY - 1);
  localparam logic [3:0] WR_LOAD = 4'((WRITE_LATENCY > 0) ? (WRITE_LATENCY - 1) : 0);

  typedef enum logic [1:0] {
    ST_IDLE       = 2'd0,
    ST_READ_WAIT  = 2'd1,
    ST_WRITE_WAIT = 2'd2
  } state_t;

  function automatic logic [31:0] lane_up(input logic [31:0] v, input logic [1:0] off);
    return v << {off, 3'b000};
  endfunction

  function automatic logic [31:0] lane_down(input logic [31:0] v, input logic [1:0] off);
    return v >> {off, 3'b000};
  endfunction

  function automatic logic in_range(input logic [29:0] idx);
    return ({2'b00, idx} < 32'(MEM_WORDS));
  endfunction

  logic [31:0] mem_r [MEM_WORDS];

  state_t      state_r, state_next_s;
  logic [3:0]  cnt_r, cnt_next_s;
  logic [29:0] ridx_r, ridx_next_s;
  logic [1:0]  roff_r, roff_next_s;
  logic [31:0] rdata_r, rdata_next_s;
  logic        valid_r, valid_next_s;

  logic        accept_s;
  logic        wr_en_s;
  logic [31:0] smask_s;
  logic [31:0] sdata_s;
  logic [31:0] rd_word_s;

  assign mem_cmd_ready   = (state_r == ST_IDLE);
  assign mem_rdata       = rdata_r;
  assign mem_rdata_valid = valid_r;

  assign accept_s = mem_cmd_start && (state_r == ST_IDLE);
  assign wr_en_s  = accept_s && mem_cmd_write && in_range(mem_addr[31:2]);
  assign smask_s  = lane_up(mem_wmask, mem_addr[1:0]);
  assign sdata_s  = lane_up(mem_wdata, mem_addr[1:0]);

  // Read data is sampled from the array at the completion edge, not at accept.
  always_comb begin
    rd_word_s = 32'h0000_0000;
    if (in_range(ridx_r)) begin
      rd_word_s = lane_down(mem_r[ridx_r[AW-1:0]], roff_r);
    end else begin
      rd_word_s = 32'h0000_0000;
    end
  end

  // Array update; contents survive reset.
  always_ff @(posedge clk) begin
    if (wr_en_s) begin
      mem_r[mem_addr[AW+1:2]] <= (mem_r[mem_addr[AW+1:2]] & ~smask_s) | (sdata_s & smask_s);
    end
  end

  // Next-state, latency counter and read-response decode.
  always_comb begin
    state_next_s = state_r;
    cnt_next_s   = cnt_r;
    ridx_next_s  = ridx_r;
    roff_next_s  = roff_r;
    rdata_next_s = rdata_r;
    valid_next_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (accept_s) begin
          if (mem_cmd_write) begin
            if (WRITE_LATENCY != 0) begin
              state_next_s = ST_WRITE_WAIT;
              cnt_next_s   = WR_LOAD;
            end else begin
              state_next_s = ST_IDLE;
            end
          end else begin
            state_next_s = ST_READ_WAIT;
            cnt_next_s   = RD_LOAD;
            ridx_next_s  = mem_addr[31:2];
            roff_next_s  = mem_addr[1:0];
          end
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_READ_WAIT: begin
        if (cnt_r == 4'd0) begin
          state_next_s = ST_IDLE;
          rdata_next_s = rd_word_s;
          valid_next_s = 1'b1;
        end else begin
          cnt_next_s = cnt_r - 4'd1;
        end
      end
      ST_WRITE_WAIT: begin
        if (cnt_r == 4'd0) begin
          state_next_s = ST_IDLE;
        end else begin
          cnt_next_s = cnt_r - 4'd1;
        end
      end
      default: begin
        state_next_s = ST_IDLE;
        cnt_next_s   = 4'd0;
      end
    endcase
  end

  // State and response registers; a pending read is dropped on reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
      cnt_r   <= 4'd0;
      ridx_r  <= 30'd0;
      roff_r  <= 2'd0;
      rdata_r <= 32'h0000_0000;
      valid_r <= 1'b0;
    end else begin
      state_r <= state_next_s;
      cnt_r   <= cnt_next_s;
      ridx_r  <= ridx_next_s;
      roff_r  <= roff_next_s;
      rdata_r <= rdata_next_s;
      valid_r <= valid_next_s;
    end
  end

endmodule

// File: tb/tb_memory_responder.sv
// Self-checking bench: four responders with different latencies against a
// transaction-level model (byte-lane arithmetic plus edge-count timing).
`timescale 1ns/1ps
module tb_memory_responder;

  localparam int NI = 4;

  function automatic int rl_of(input int g);
    case (g)
      0:       return 2;
      1:       return 15;
      2:       return 1;
      default: return 4;
    endcase
  endfunction

  function automatic int wl_of(input int g);
    case (g)
      0:       return 0;
      1:       return 3;
      2:       return 1;
      default: return 2;
    endcase
  endfunction

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start [NI];
  logic        wr    [NI];
  logic [31:0] addr  [NI];
  logic [31:0] wdata [NI];
  logic [31:0] wmask [NI];
  logic        ready_w [NI];
  logic        valid_w [NI];
  logic [31:0] rdata_w [NI];

  always #5 clk = ~clk;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    memory_responder #(
      .MEM_WORDS    (4096),
      .READ_LATENCY (rl_of(g)),
      .WRITE_LATENCY(wl_of(g)),
      .MEM_INIT_FILE("")
    ) u_dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .mem_cmd_start  (start[g]),
      .mem_cmd_write  (wr[g]),
      .mem_cmd_ready  (ready_w[g]),
      .mem_addr       (addr[g]),
      .mem_wdata      (wdata[g]),
      .mem_wmask      (wmask[g]),
      .mem_rdata      (rdata_w[g]),
      .mem_rdata_valid(valid_w[g])
    );
  end

  // Reference model state
  logic [31:0] mm [NI][4096];
  logic        m_ready [NI];
  logic        m_valid [NI];
  logic [31:0] m_rdata [NI];
  logic        pend    [NI];
  logic        acc     [NI];
  logic [31:0] paddr   [NI];
  int          done_cyc [NI];
  int          free_cyc [NI];
  int          acc_cyc  [NI];
  int          cyc = 0;
  int          errs = 0;
  int          checks = 0;

  function automatic logic [31:0] wr_merge(input logic [31:0] old, input logic [31:0] wd,
                                           input logic [31:0] wm, input logic [1:0] off);
    logic [31:0] r;
    r = old;
    for (int j = 0; j < 4; j++)
      if (wm[8*j] && (j + int'(off)) < 4) r[8*(j+int'(off)) +: 8] = wd[8*j +: 8];
    return r;
  endfunction

  function automatic logic [31:0] rd_lane(input logic [31:0] w, input logic [1:0] off);
    logic [31:0] r;
    r = 32'h0;
    for (int j = 0; j < 4; j++)
      if ((j + int'(off)) < 4) r[8*j +: 8] = w[8*(j+int'(off)) +: 8];
    return r;
  endfunction

  task automatic chk(input string nm, input int g, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s inst%0d cyc=%0d: got %h expected %h", nm, g, cyc, act, exp);
    end
  endtask

  // Model: ready/valid derived from accept-edge arithmetic, data from byte lanes.
  initial begin
    int unsigned ix;
    for (int g = 0; g < NI; g++) begin
      m_ready[g] = 1'b1; m_valid[g] = 1'b0; m_rdata[g] = 32'h0;
      pend[g] = 1'b0; acc[g] = 1'b0; free_cyc[g] = 0; done_cyc[g] = 0; acc_cyc[g] = 0;
    end
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        for (int g = 0; g < NI; g++) begin
          m_ready[g] = 1'b1; m_valid[g] = 1'b0; m_rdata[g] = 32'h0;
          pend[g] = 1'b0; acc[g] = 1'b0; free_cyc[g] = 0;
        end
      end else begin
        cyc = cyc + 1;
        for (int g = 0; g < NI; g++) begin
          acc[g] = 1'b0;
          m_valid[g] = 1'b0;
          if (pend[g] && cyc == done_cyc[g]) begin
            ix = paddr[g][31:2];
            m_rdata[g] = (ix < 4096) ? rd_lane(mm[g][ix], paddr[g][1:0]) : 32'h0;
            m_valid[g] = 1'b1;
            pend[g] = 1'b0;
          end
          if (m_ready[g] && start[g]) begin
            acc[g] = 1'b1;
            acc_cyc[g] = cyc;
            if (wr[g]) begin
              ix = addr[g][31:2];
              if (ix < 4096) mm[g][ix] = wr_merge(mm[g][ix], wdata[g], wmask[g], addr[g][1:0]);
              free_cyc[g] = cyc + wl_of(g);
            end else begin
              pend[g] = 1'b1;
              paddr[g] = addr[g];
              done_cyc[g] = cyc + rl_of(g);
              free_cyc[g] = done_cyc[g];
            end
          end
          m_ready[g] = (cyc >= free_cyc[g]);
        end
      end
    end
  end

  // Every-cycle comparison of all outputs against the model.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      for (int g = 0; g < NI; g++) begin
        chk("ready", g, {31'd0, ready_w[g]}, {31'd0, m_ready[g]});
        chk("valid", g, {31'd0, valid_w[g]}, {31'd0, m_valid[g]});
        chk("rdata", g, rdata_w[g], m_rdata[g]);
      end
    end
  end

  // Present a command from the current negedge and hold it until accepted.
  task automatic issue(input int g, input logic w, input logic [31:0] a,
                       input logic [31:0] d, input logic [31:0] m);
    int n;
    n = 0;
    start[g] = 1'b1; wr[g] = w; addr[g] = a; wdata[g] = d; wmask[g] = m;
    do begin
      @(negedge clk);
      n++;
    end while (!acc[g] && n < 50);
    if (!acc[g]) begin
      checks++; errs++;
      $display("FAIL accept_timeout inst%0d: got no accept expected accept within 50", g);
    end
    start[g] = 1'b0;
  endtask

  task automatic wait_valid(input int g, output logic [31:0] d, output int lat);
    int n;
    n = 0;
    while (!valid_w[g] && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (!valid_w[g]) begin
      checks++; errs++;
      $display("FAIL valid_timeout inst%0d: got no pulse expected pulse within 40", g);
      d = 32'h0; lat = -1;
    end else begin
      d = rdata_w[g];
      lat = cyc - acc_cyc[g];
    end
  endtask

  initial begin
    logic [31:0] d;
    int lat, t0, npulse;
    for (int g = 0; g < NI; g++) begin
      start[g] = 1'b0; wr[g] = 1'b0; addr[g] = 32'h0; wdata[g] = 32'h0; wmask[g] = 32'h0;
    end
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      for (int g = 0; g < NI; g++) begin
        chk("rst_ready", g, {31'd0, ready_w[g]}, 32'd1);
        chk("rst_valid", g, {31'd0, valid_w[g]}, 32'd0);
        chk("rst_rdata", g, rdata_w[g], 32'h0000_0000);
      end
    end

    // Word write then back-to-back read, R=2 W=0
    issue(0, 1'b1, 32'h100, 32'hDEAD_BEEF, 32'hFFFF_FFFF);
    t0 = acc_cyc[0];
    issue(0, 1'b0, 32'h100, 32'h0, 32'h0);
    chk("b2b_accept_gap", 0, 32'(acc_cyc[0] - t0), 32'd1);
    wait_valid(0, d, lat);
    chk("sw_lw_data", 0, d, 32'hDEAD_BEEF);
    chk("rd_latency_2", 0, 32'(lat), 32'd2);

    // Byte and halfword lanes
    issue(0, 1'b1, 32'h200, 32'h1122_3344, 32'hFFFF_FFFF);
    issue(0, 1'b1, 32'h202, 32'h0000_00AA, 32'h0000_00FF);
    issue(0, 1'b0, 32'h200, 32'h0, 32'h0);
    wait_valid(0, d, lat);
    chk("sb_merge", 0, d, 32'h11AA_3344);
    issue(0, 1'b0, 32'h203, 32'h0, 32'h0);
    wait_valid(0, d, lat);
    chk("rd_off3", 0, d, 32'h0000_0011);
    issue(0, 1'b1, 32'h200, 32'h0000_BEEF, 32'h0000_FFFF);
    issue(0, 1'b0, 32'h200, 32'h0, 32'h0);
    wait_valid(0, d, lat);
    chk("sh_merge", 0, d, 32'h11AA_BEEF);

    // Backpressure W=3, then R=15 read with a single pulse
    issue(1, 1'b1, 32'h100, 32'h1234_5678, 32'hFFFF_FFFF);
    t0 = acc_cyc[1];
    issue(1, 1'b1, 32'h104, 32'h0BAD_F00D, 32'hFFFF_FFFF);
    chk("w3_accept_gap", 1, 32'(acc_cyc[1] - t0), 32'd4);
    issue(1, 1'b0, 32'h100, 32'h0, 32'h0);
    wait_valid(1, d, lat);
    chk("r15_data", 1, d, 32'h1234_5678);
    chk("rd_latency_15", 1, 32'(lat), 32'd15);
    npulse = 0;
    repeat (20) begin
      @(negedge clk);
      if (valid_w[1]) npulse++;
    end
    chk("r15_extra_pulses", 1, 32'(npulse), 32'd0);

    // R=1, W=1
    issue(2, 1'b1, 32'h100, 32'h5A5A_0001, 32'hFFFF_FFFF);
    t0 = acc_cyc[2];
    issue(2, 1'b0, 32'h100, 32'h0, 32'h0);
    chk("w1_accept_gap", 2, 32'(acc_cyc[2] - t0), 32'd2);
    wait_valid(2, d, lat);
    chk("r1_data", 2, d, 32'h5A5A_0001);
    chk("rd_latency_1", 2, 32'(lat), 32'd1);

    // Reset during a pending read, R=4
    issue(3, 1'b1, 32'h100, 32'hCAFE_F00D, 32'hFFFF_FFFF);
    issue(3, 1'b0, 32'h100, 32'h0, 32'h0);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst_ready", 3, {31'd0, ready_w[3]}, 32'd1);
    chk("midrst_valid", 3, {31'd0, valid_w[3]}, 32'd0);
    chk("midrst_rdata", 3, rdata_w[3], 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    npulse = 0;
    repeat (10) begin
      @(negedge clk);
      if (valid_w[3]) npulse++;
    end
    chk("dropped_read_pulses", 3, 32'(npulse), 32'd0);
    issue(3, 1'b0, 32'h100, 32'h0, 32'h0);
    wait_valid(3, d, lat);
    chk("post_rst_data", 3, d, 32'hCAFE_F00D);
    issue(3, 1'b0, 32'hFFFF_FFFC, 32'h0, 32'h0);
    wait_valid(3, d, lat);
    chk("oor_read_data", 3, d, 32'h0000_0000);
    chk("oor_read_lat", 3, 32'(lat), 32'd4);

    // Preload the random window so every in-range read is of known data
    for (int g = 0; g < NI; g++)
      for (int w = 0; w < 32; w++)
        issue(g, 1'b1, 32'(w * 4), $urandom, 32'hFFFF_FFFF);

    // Random traffic; a refused command is held unchanged until accepted
    for (int c = 0; c < 2000; c++) begin
      @(negedge clk);
      for (int g = 0; g < NI; g++) begin
        if (!start[g] || acc[g]) begin
          if ($urandom_range(0, 99) < 65) begin
            start[g] = 1'b1;
            wr[g]    = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 9) == 0) begin
              case ($urandom_range(0, 2))
                0:       addr[g] = 32'hFFFF_FFFC;
                1:       addr[g] = 32'h0000_4000 | ($urandom & 32'h0000_3FFF);
                default: addr[g] = $urandom | 32'h8000_0000;
              endcase
            end else begin
              addr[g] = ($urandom_range(0, 31) << 2) | $urandom_range(0, 3);
            end
            wdata[g] = $urandom;
            case ($urandom_range(0, 2))
              0:       wmask[g] = 32'h0000_00FF;
              1:       wmask[g] = 32'h0000_FFFF;
              default: wmask[g] = 32'hFFFF_FFFF;
            endcase
          end else begin
            start[g] = 1'b0;
          end
        end
      end
    end
    @(negedge clk);
    for (int g = 0; g < NI; g++) start[g] = 1'b0;
    repeat (25) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
